// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3).
// One shift per clock; a W-bit operand converts in W clocks after start is
// accepted, followed by a single-cycle done pulse with the new bcd_out.
//
// state | meaning
// IDLE  | waiting for start; bcd_out holds the last result
// SHIFT | correcting digits and shifting, one bit per clock
module bin_to_bcd_seq #(
   parameter int W      = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [W-1:0]          bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out
);

   localparam int CW = $clog2(W + 1);
   localparam int BW = 4 * DIGITS;

   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   localparam longint unsigned MAX_BIN = (64'd1 << W) - 64'd1;

   // Reject widths the iteration scheme cannot handle and digit counts too
   // small to hold the largest operand.
   generate
      if (W < 4 || W > 32) begin : g_bad_width
         $fatal(1, "bin_to_bcd_seq: W must be in 4..32");
      end
      if (pow10(DIGITS) <= MAX_BIN) begin : g_bad_digits
         $fatal(1, "bin_to_bcd_seq: DIGITS too small for W");
      end
   endgenerate

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    sr_bin, sr_bin_nxt;
   logic [BW-1:0]   sr_bcd, sr_bcd_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [BW-1:0]   bcd_out_nxt;
   logic            done_nxt;
   logic [BW-1:0]   bcd_adj;
   logic            last_shift;

   // Register state, shift register, counter and the result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         sr_bin  <= '0;
         sr_bcd  <= '0;
         cnt     <= '0;
         done    <= 1'b0;
         bcd_out <= '0;
      end else begin
         state   <= state_nxt;
         sr_bin  <= sr_bin_nxt;
         sr_bcd  <= sr_bcd_nxt;
         cnt     <= cnt_nxt;
         done    <= done_nxt;
         bcd_out <= bcd_out_nxt;
      end
   end

   // Add 3 to every digit >= 5, all digits judged on their pre-shift value.
   always_comb begin
      bcd_adj = sr_bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (sr_bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = sr_bcd[4*i +: 4] + 4'd3;
      end
   end

   assign last_shift = (cnt == CW'(W - 1));

   // Next-state and datapath control; done defaults low so it pulses once.
   always_comb begin
      state_nxt   = state;
      sr_bin_nxt  = sr_bin;
      sr_bcd_nxt  = sr_bcd;
      cnt_nxt     = cnt;
      bcd_out_nxt = bcd_out;
      done_nxt    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               sr_bin_nxt = bin_in;
               sr_bcd_nxt = '0;
               cnt_nxt    = '0;
               state_nxt  = SHIFT;
            end
         end
         SHIFT: begin
            sr_bcd_nxt = {bcd_adj[BW-2:0], sr_bin[W-1]};
            sr_bin_nxt = {sr_bin[W-2:0], 1'b0};
            cnt_nxt    = cnt + CW'(1);
            if (last_shift) begin
               bcd_out_nxt = {bcd_adj[BW-2:0], sr_bin[W-1]};
               done_nxt    = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == SHIFT);

endmodule
